axil_slave_to_stream: RTL and testbench

AXI-lite slave that turns every accepted write into one stream beat carrying {address, data}. It is the stream-producing counterpart of the stream-to-AXI-lite master, so a master/slave pair can bridge a stream across an AXI-lite link and back. It keeps a small shadow register file of forwarded writes, which AXI-lite reads return.

---
 rtl/axil_pkg.sv | 28 ++
 rtl/axil_shadow_rf.sv | 38 +++
 rtl/axil_slave_to_stream.sv | 211 +++++++++++++++++++++
 tb/tb_axil_slave_to_stream.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-lite <-> stream bridge pair.
//
// Contents:
//   RESP_OKAY / RESP_SLVERR : AXI-lite response codes
//   w_state_t               : write-side FSM states (idle, streaming beat, response)
//   r_state_t               : read-side FSM states (idle, data presented)
//   idx_width()             : index width for an n-entry register array (min 1)
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_STREAM = 2'd1,
        W_RESP   = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_shadow_rf.sv
// Shadow register file holding the last value forwarded to each address.
//
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset (clears all entries)
//   we            : write enable
//   waddr, wdata  : write port index and data
//   raddr, rdata  : combinational read port
module axil_shadow_rf
    import axil_pkg::*;
#(
    parameter int NREG    = 16,
    parameter int DATA_WD = 8,
    parameter int IDX_WD  = idx_width(NREG)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               we,
    input  logic [IDX_WD-1:0]  waddr,
    input  logic [DATA_WD-1:0] wdata,
    input  logic [IDX_WD-1:0]  raddr,
    output logic [DATA_WD-1:0] rdata
);

    logic [DATA_WD-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axil_slave_to_stream.sv
// AXI-lite slave that forwards every accepted write as one stream beat
// {address, data} and mirrors forwarded writes into a shadow register file
// that AXI-lite reads return.
//
// Handshakes: every channel uses valid/ready; a transfer happens on the
// rising clk edge where both are 1. A producer holds valid and its payload
// stable until that edge; ready may change freely.
//
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   awaddr/awvalid/awready    : write address channel
//   wdata/wvalid/wready       : write data channel
//   bresp/bvalid/bready       : write response (always OKAY)
//   araddr/arvalid/arready    : read address channel
//   rdata/rresp/rvalid/rready : read data (SLVERR for araddr >= NREG)
//   tdata/tkeep/tvalid/tready : output stream, tdata = {addr, data}
//   wr_state_dbg, rd_state_dbg: current write / read FSM state
module axil_slave_to_stream
    import axil_pkg::*;
#(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 8,
    parameter int BYTE_WD = (ADDR_WD + DATA_WD) >> 3,
    parameter int NREG    = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ADDR_WD-1:0]         awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WD-1:0]         wdata,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_WD-1:0]         araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_WD-1:0]         rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [ADDR_WD+DATA_WD-1:0] tdata,
    output logic [BYTE_WD-1:0]         tkeep,
    output logic                       tvalid,
    input  logic                       tready,
    output logic [1:0]                 wr_state_dbg,
    output logic                       rd_state_dbg
);

    localparam int IDX_WD = idx_width(NREG);
    // One extra bit so NREG == 2**ADDR_WD is representable.
    localparam logic [ADDR_WD:0] NREG_W = (ADDR_WD + 1)'(NREG);

    function automatic logic in_range(input logic [ADDR_WD-1:0] a);
        return {1'b0, a} < NREG_W;
    endfunction

    w_state_t           w_state;
    r_state_t           r_state;
    logic               aw_held;
    logic               w_held;
    logic [ADDR_WD-1:0] addr_q;
    logic [DATA_WD-1:0] data_q;

    logic               aw_fire;
    logic               w_fire;
    logic               ar_fire;
    logic               beat_fire;
    logic               aw_held_nx;
    logic               w_held_nx;
    logic [ADDR_WD-1:0] addr_nx;
    logic [DATA_WD-1:0] data_nx;
    logic               rf_we;
    logic [DATA_WD-1:0] rf_rdata;

    assign aw_fire    = awvalid & awready;
    assign w_fire     = wvalid & wready;
    assign ar_fire    = arvalid & arready;
    assign beat_fire  = tvalid & tready;

    // Holding state as it will be after this edge; lets the beat launch on
    // the same edge that completes the address/data pair.
    assign aw_held_nx = aw_held | aw_fire;
    assign w_held_nx  = w_held | w_fire;
    assign addr_nx    = aw_fire ? awaddr : addr_q;
    assign data_nx    = w_fire ? wdata : data_q;

    // Shadow is written on the beat handshake; out-of-range writes are
    // streamed but never stored.
    assign rf_we      = beat_fire & in_range(addr_q);

    assign wr_state_dbg = w_state;
    assign rd_state_dbg = r_state;

    axil_shadow_rf #(
        .NREG    (NREG),
        .DATA_WD (DATA_WD),
        .IDX_WD  (IDX_WD)
    ) u_shadow (
        .clk   (clk),
        .rstn  (rstn),
        .we    (rf_we),
        .waddr (addr_q[IDX_WD-1:0]),
        .wdata (data_q),
        .raddr (araddr[IDX_WD-1:0]),
        .rdata (rf_rdata)
    );

    // Write side: collect AW and W independently, emit one beat, then respond.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            tvalid  <= 1'b0;
            tdata   <= '0;
            tkeep   <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_held <= aw_held_nx;
                    w_held  <= w_held_nx;
                    addr_q  <= addr_nx;
                    data_q  <= data_nx;
                    if (aw_held_nx && w_held_nx) begin
                        w_state <= W_STREAM;
                        tvalid  <= 1'b1;
                        tdata   <= {addr_nx, data_nx};
                        tkeep   <= '1;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                    end else begin
                        awready <= !aw_held_nx;
                        wready  <= !w_held_nx;
                    end
                end
                W_STREAM: begin
                    if (tready) begin
                        tvalid  <= 1'b0;
                        tkeep   <= '0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read side: the shadow is sampled on the AR edge, so a read landing on
    // the same edge as a beat handshake sees the pre-write value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_fire) begin
                        if (in_range(araddr)) begin
                            rdata <= rf_rdata;
                            rresp <= RESP_OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_slave_to_stream.sv
// Bench for axil_slave_to_stream: directed scenarios plus a randomized phase,
// with a scoreboard of expected beats, write responses and read responses
// drained by independent monitors.
module tb_axil_slave_to_stream;
    import axil_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int BW   = (AW + DW) >> 3;
    localparam int NREG = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [AW-1:0]    awaddr;
    logic             awvalid, awready;
    logic [DW-1:0]    wdata;
    logic             wvalid, wready;
    logic [1:0]       bresp;
    logic             bvalid, bready;
    logic [AW-1:0]    araddr;
    logic             arvalid, arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid, rready;
    logic [AW+DW-1:0] tdata;
    logic [BW-1:0]    tkeep;
    logic             tvalid, tready;
    logic [1:0]       wr_state_dbg;
    logic             rd_state_dbg;

    axil_slave_to_stream #(
        .DATA_WD (DW),
        .ADDR_WD (AW),
        .BYTE_WD (BW),
        .NREG    (NREG)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .tdata        (tdata),
        .tkeep        (tkeep),
        .tvalid       (tvalid),
        .tready       (tready),
        .wr_state_dbg (wr_state_dbg),
        .rd_state_dbg (rd_state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int b_count  = 0;
    int r_count  = 0;

    logic [AW+DW-1:0] exp_beat_q[$];
    logic [1:0]       exp_b_q[$];
    logic [DW+1:0]    exp_r_q[$];

    logic [AW+DW-1:0] e_beat;
    logic [1:0]       e_b;
    logic [DW+1:0]    e_r;
    logic [AW+DW-1:0] held_tdata;
    logic [DW-1:0]    old_val;

    // Reference view of the register space: a plain array indexed by address.
    logic [DW-1:0] model [0:255];

    logic t_rand = 1'b0;
    logic b_rand = 1'b0;
    logic r_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    // Random sink/master readiness, applied away from both clock edges.
    always @(posedge clk) begin
        #2;
        if (t_rand) tready = 1'($urandom_range(0, 1));
        if (b_rand) bready = 1'($urandom_range(0, 1));
        if (r_rand) rready = 1'($urandom_range(0, 1));
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rstn && tvalid && tready) begin
            if (exp_beat_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL beat_unexpected: actual=0x%0h required=none", tdata);
            end else begin
                e_beat = exp_beat_q.pop_front();
                check("beat_tdata", 32'(tdata), 32'(e_beat));
                check("beat_tkeep", 32'(tkeep), 32'({BW{1'b1}}));
            end
        end
        if (rstn && bvalid && bready) begin
            if (exp_b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: actual=0x%0h required=none", bresp);
            end else begin
                e_b = exp_b_q.pop_front();
                check("bresp", 32'(bresp), 32'(e_b));
            end
            b_count++;
        end
        if (rstn && rvalid && rready) begin
            if (exp_r_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: actual=0x%0h required=none", {rresp, rdata});
            end else begin
                e_r = exp_r_q.pop_front();
                check("rresp_rdata", 32'({rresp, rdata}), 32'(e_r));
            end
            r_count++;
        end
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input int aw_dly, input int w_dly);
        int b0;
        int n;
        exp_beat_q.push_back({a, d});
        exp_b_q.push_back(RESP_OKAY);
        if (int'(a) < NREG) model[a] = d;
        b0 = b_count;
        fork
            begin
                int k;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr = a; awvalid = 1'b1; k = 0;
                @(negedge clk);
                while (!awready && k < 200) begin @(negedge clk); k++; end
                if (!awready) timeout("aw_accept");
                @(posedge clk); #1;
                awvalid = 1'b0;
            end
            begin
                int k;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata = d; wvalid = 1'b1; k = 0;
                @(negedge clk);
                while (!wready && k < 200) begin @(negedge clk); k++; end
                if (!wready) timeout("w_accept");
                @(posedge clk); #1;
                wvalid = 1'b0;
            end
        join
        n = 0;
        while (b_count == b0 && n < 300) begin @(posedge clk); #1; n++; end
        if (b_count == b0) timeout("b_resp");
    endtask

    task automatic do_read(input logic [7:0] a);
        int r0;
        int n;
        if (int'(a) < NREG) exp_r_q.push_back({RESP_OKAY, model[a]});
        else                exp_r_q.push_back({RESP_SLVERR, 8'h00});
        r0 = r_count;
        araddr = a; arvalid = 1'b1; n = 0;
        @(negedge clk);
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (!arready) timeout("ar_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (r_count == r0 && n < 200) begin @(posedge clk); #1; n++; end
        if (r_count == r0) timeout("r_resp");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; tready = 1'b0;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 0);
        check("rst_wready",  32'(wready),  0);
        check("rst_arready", 32'(arready), 0);
        check("rst_tvalid",  32'(tvalid),  0);
        check("rst_tkeep",   32'(tkeep),   0);
        check("rst_tdata",   32'(tdata),   0);
        check("rst_bvalid",  32'(bvalid),  0);
        check("rst_rvalid",  32'(rvalid),  0);
        check("rst_rdata",   32'(rdata),   0);
        check("rst_rresp",   32'(rresp),   0);
        check("rst_bresp",   32'(bresp),   0);
        @(posedge clk); #3;
        rstn = 1'b1;
        #1;
        check("ready_before_edge", 32'({awready, wready, arready}), 0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'({awready, wready, arready}), 32'h7);

        // Same-cycle AW/W with an always-ready sink
        tready = 1'b1; bready = 1'b1; rready = 1'b1;
        fork
            do_write(8'h03, 8'hA5, 0, 0);
            begin
                @(posedge clk); #1;
                check("same_tvalid", 32'(tvalid), 1);
                check("same_tdata",  32'(tdata), 32'h03A5);
                check("same_tkeep",  32'(tkeep), 32'h3);
                check("same_bvalid_early", 32'(bvalid), 0);
                @(posedge clk); #1;
                check("same_bvalid", 32'(bvalid), 1);
                check("same_bresp",  32'(bresp), 0);
            end
        join
        do_read(8'h03);

        // W first, AW three cycles later
        fork
            do_write(8'h07, 8'h5A, 3, 0);
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("split_awready", 32'(awready), 1);
                    check("split_wready",  32'(wready), 0);
                    check("split_tvalid",  32'(tvalid), 0);
                end
            end
        join
        do_read(8'h07);

        // Stream and response backpressure
        tready = 1'b0; bready = 1'b0;
        fork
            do_write(8'h0B, 8'h3C, 0, 0);
            begin
                @(posedge clk); #2;
                held_tdata = tdata;
                check("bp_tdata", 32'(held_tdata), 32'h0B3C);
                awaddr = 8'h09; awvalid = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_tvalid",  32'(tvalid), 1);
                    check("bp_stable",  32'(tdata), 32'(held_tdata));
                    check("bp_bvalid",  32'(bvalid), 0);
                    check("bp_awready", 32'(awready), 0);
                end
                @(posedge clk); #1;
                tready = 1'b1;
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("bstall_bvalid",  32'(bvalid), 1);
                    check("bstall_awready", 32'(awready), 0);
                end
                @(posedge clk); #1;
                awvalid = 1'b0;
                bready = 1'b1;
            end
        join

        // Range boundary and out-of-range
        do_write(8'h0F, 8'hC3, 1, 2);
        do_read(8'h0F);
        do_write(8'h10, 8'h77, 0, 1);
        do_read(8'h10);
        do_write(8'h20, 8'($urandom_range(0, 255)), 2, 0);
        do_read(8'h20);

        // Read captured on the same edge as the beat handshake to that register
        do_write(8'h02, 8'h11, 0, 0);
        old_val = model[2];
        tready = 1'b0;
        fork
            do_write(8'h02, 8'h22, 0, 0);
            begin
                int n;
                int r0;
                @(posedge clk); #2;
                check("coll_tvalid", 32'(tvalid), 1);
                exp_r_q.push_back({RESP_OKAY, old_val});
                r0 = r_count;
                araddr = 8'h02; arvalid = 1'b1; tready = 1'b1;
                @(negedge clk);
                check("coll_arready", 32'(arready), 1);
                @(posedge clk); #1;
                arvalid = 1'b0;
                n = 0;
                while (r_count == r0 && n < 50) begin @(posedge clk); #1; n++; end
                if (r_count == r0) timeout("coll_r_resp");
            end
        join
        do_read(8'h02);

        // Randomized traffic with random backpressure
        t_rand = 1'b1; b_rand = 1'b1; r_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                do_read(8'($urandom_range(0, 31)));
        end
        @(posedge clk); #1;
        t_rand = 1'b0; b_rand = 1'b0; r_rand = 1'b0;
        tready = 1'b0; bready = 1'b1; rready = 1'b0;

        // Reset while a beat and a read response are pending
        awaddr = 8'h05; awvalid = 1'b1; wdata = 8'h99; wvalid = 1'b1;
        araddr = 8'h01; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("mid_tvalid", 32'(tvalid), 1);
        check("mid_rvalid", 32'(rvalid), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_valids", 32'({tvalid, bvalid, rvalid}), 0);
        check("mid_rst_readies", 32'({awready, wready, arready}), 0);
        clear_model();
        tready = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #3;
        rstn = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'({awready, wready, arready}), 0);
        @(posedge clk); #1;
        check("rel_ready_after_edge", 32'({awready, wready, arready}), 32'h7);
        repeat (10) begin
            @(negedge clk);
            check("rel_no_stale", 32'({tvalid, bvalid, rvalid}), 0);
        end
        @(posedge clk); #1;
        do_read(8'h02);
        do_write(8'h04, 8'h6E, 0, 0);
        do_read(8'h04);

        // Every expectation must have been consumed
        repeat (4) @(posedge clk);
        check("beat_q_empty", 32'(exp_beat_q.size()), 0);
        check("b_q_empty",    32'(exp_b_q.size()), 0);
        check("r_q_empty",    32'(exp_r_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
